alu_issue_stage: RTL and testbench

- Pipeline stage directly upstream of the 32-bit combinational ALU.
- Accepts a compact 4-bit operation code plus two 32-bit operands over a valid/ready handshake.
- Decodes the op into the ALU's 4-bit ALU_control and 3-bit bonus_control fields, registers them with the operands to drive the ALU, then captures the ALU's result and flags into an output register with its own valid/ready handshake.
- Two-stage, full-throughput, in-order.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_op_decode.sv | 60 ++++++
 rtl/alu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared encodings for the ALU issue path. Compact operation
//               codes presented on the issue interface, the ALU_control and
//               bonus_control field values understood by the 32-bit ALU, and
//               the bundle of decoded control bits carried by stage 1.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Compact issue-side operation codes; 10..15 are illegal.
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SGE  = 4'd7;
    localparam logic [3:0] OP_SLE  = 4'd8;
    localparam logic [3:0] OP_SEQ  = 4'd9;

    // ALU_control field values.
    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NAND = 4'b1101;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;

    // bonus_control field values; only meaningful alongside CTRL_SLT.
    localparam logic [2:0] BON_LT = 3'b000;
    localparam logic [2:0] BON_GE = 3'b001;
    localparam logic [2:0] BON_LE = 3'b010;
    localparam logic [2:0] BON_EQ = 3'b110;

    // Decoded control carried alongside the operands.
    typedef struct packed {
        logic [3:0] ctrl;
        logic [2:0] bonus;
        logic       is_arith;
        logic       err;
    } dec_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Purely combinational translation of a compact 4-bit operation
//               code into the ALU_control / bonus_control fields, plus flags
//               marking carry/overflow-producing ops and illegal codes.
//   i_op       : compact operation code
//   o_ctrl     : ALU_control field
//   o_bonus    : bonus_control field
//   o_is_arith : op is ADD or SUB (carry/overflow are meaningful)
//   o_err      : op code is illegal (10..15)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] i_op,
    output logic [3:0] o_ctrl,
    output logic [2:0] o_bonus,
    output logic       o_is_arith,
    output logic       o_err
);

    always_comb begin
        o_ctrl     = CTRL_AND;
        o_bonus    = BON_LT;
        o_is_arith = 1'b0;
        o_err      = 1'b0;
        case (i_op)
            OP_AND:  o_ctrl = CTRL_AND;
            OP_OR:   o_ctrl = CTRL_OR;
            OP_ADD: begin
                o_ctrl     = CTRL_ADD;
                o_is_arith = 1'b1;
            end
            OP_SUB: begin
                o_ctrl     = CTRL_SUB;
                o_is_arith = 1'b1;
            end
            OP_NOR:  o_ctrl = CTRL_NOR;
            OP_NAND: o_ctrl = CTRL_NAND;
            OP_SLT:  o_ctrl = CTRL_SLT;
            OP_SGE: begin
                o_ctrl  = CTRL_SLT;
                o_bonus = BON_GE;
            end
            OP_SLE: begin
                o_ctrl  = CTRL_SLT;
                o_bonus = BON_LE;
            end
            OP_SEQ: begin
                o_ctrl  = CTRL_SLT;
                o_bonus = BON_EQ;
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Two-stage, full-throughput, in-order issue stage in front of
//               the combinational 32-bit ALU. Stage 1 registers the decoded
//               command and drives the ALU directly; stage 2 captures the ALU
//               result and flags behind a valid/ready output handshake.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : command handshake
//   in_op, in_src1, in_src2      : compact op code and operands
//   alu_rst_n                    : ALU reset (inverse of rst)
//   alu_src1/2, alu_ctrl/bonus   : registered command to the ALU
//   alu_result/zero/cout/overflow: combinational ALU response
//   out_valid/out_ready          : result handshake
//   out_result/zero/cout/overflow/err : captured result and flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             alu_rst_n,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       alu_bonus,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             out_err
);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    dec_t w_dec;

    alu_op_decode u_decode (
        .i_op       (in_op),
        .o_ctrl     (w_dec.ctrl),
        .o_bonus    (w_dec.bonus),
        .o_is_arith (w_dec.is_arith),
        .o_err      (w_dec.err)
    );

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic             r_s1_valid;
    dec_t             r_s1_dec;
    logic [WIDTH-1:0] r_s1_src1;
    logic [WIDTH-1:0] r_s1_src2;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_zero;
    logic             r_out_cout;
    logic             r_out_overflow;
    logic             r_out_err;

    logic w_s2_free;
    logic w_s1_adv;
    logic w_accept;

    // in_ready depends on out_ready but never on in_valid.
    assign w_s2_free = !r_out_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_accept  = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1: decoded command, drives the ALU
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_dec   <= '0;
            r_s1_src1  <= '0;
            r_s1_src2  <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_dec   <= w_dec;
                // Illegal ops present zero operands so the ALU sees a benign AND.
                r_s1_src1  <= w_dec.err ? '0 : in_src1;
                r_s1_src2  <= w_dec.err ? '0 : in_src2;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: captured result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_zero     <= 1'b0;
            r_out_cout     <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_err      <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_out_valid    <= 1'b1;
                r_out_result   <= r_s1_dec.err ? '0 : alu_result;
                r_out_zero     <= alu_zero && !r_s1_dec.err;
                // Carry/overflow only mean something for ADD/SUB.
                r_out_cout     <= alu_cout && r_s1_dec.is_arith && !r_s1_dec.err;
                r_out_overflow <= alu_overflow && r_s1_dec.is_arith && !r_s1_dec.err;
                r_out_err      <= r_s1_dec.err;
            end else if (out_ready) begin
                r_out_valid    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_rst_n    = ~rst;
    assign alu_src1     = r_s1_src1;
    assign alu_src2     = r_s1_src2;
    assign alu_ctrl     = r_s1_dec.ctrl;
    assign alu_bonus    = r_s1_dec.bonus;

    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_zero     = r_out_zero;
    assign out_cout     = r_out_cout;
    assign out_overflow = r_out_overflow;
    assign out_err      = r_out_err;

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Directed self-checking bench for alu_issue_stage. A small
//               behavioural model of the downstream ALU answers the stage's
//               registered command; expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_src1;
    logic [WIDTH-1:0] in_src2;
    logic             alu_rst_n;
    logic [WIDTH-1:0] alu_src1;
    logic [WIDTH-1:0] alu_src2;
    logic [3:0]       alu_ctrl;
    logic [2:0]       alu_bonus;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_cout;
    logic             alu_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_cout;
    logic             out_overflow;
    logic             out_err;

    int checks   = 0;
    int failures = 0;

    alu_issue_stage #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_src1      (in_src1),
        .in_src2      (in_src2),
        .alu_rst_n    (alu_rst_n),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_ctrl     (alu_ctrl),
        .alu_bonus    (alu_bonus),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_cout     (out_cout),
        .out_overflow (out_overflow),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU. The adder always runs, so carry/overflow are
    // non-zero on logic ops too; the stage must mask them.
    logic [32:0] w_sum;
    logic [32:0] w_dif;
    logic        w_lt;
    logic        w_eq;
    always_comb begin
        w_sum        = {1'b0, alu_src1} + {1'b0, alu_src2};
        w_dif        = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        w_lt         = $signed(alu_src1) < $signed(alu_src2);
        w_eq         = alu_src1 == alu_src2;
        alu_result   = '0;
        alu_cout     = w_sum[32];
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (w_sum[31] != alu_src1[31]);
        case (alu_ctrl)
            4'b0000: alu_result = alu_src1 & alu_src2;
            4'b0001: alu_result = alu_src1 | alu_src2;
            4'b0010: alu_result = w_sum[31:0];
            4'b1100: alu_result = ~(alu_src1 | alu_src2);
            4'b1101: alu_result = ~(alu_src1 & alu_src2);
            4'b0110, 4'b0111: begin
                alu_cout     = w_dif[32];
                alu_overflow = (alu_src1[31] != alu_src2[31]) && (w_dif[31] != alu_src1[31]);
                if (alu_ctrl == 4'b0110) alu_result = w_dif[31:0];
                else begin
                    case (alu_bonus)
                        3'b000:  alu_result = {31'd0, w_lt};
                        3'b001:  alu_result = {31'd0, !w_lt};
                        3'b010:  alu_result = {31'd0, w_lt || w_eq};
                        3'b110:  alu_result = {31'd0, w_eq};
                        default: alu_result = '0;
                    endcase
                end
            end
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
    endtask

    // Check full output register contents.
    task automatic chk_out(input string tag, input logic v, input logic [31:0] res,
                           input logic z, input logic c, input logic o, input logic e);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".result"}, out_result, res);
        chk({tag, ".zero"}, {31'd0, out_zero}, {31'd0, z});
        chk({tag, ".cout"}, {31'd0, out_cout}, {31'd0, c});
        chk({tag, ".ovf"}, {31'd0, out_overflow}, {31'd0, o});
        chk({tag, ".err"}, {31'd0, out_err}, {31'd0, e});
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        tick();
        chk("rst_alu_rst_n_low", {31'd0, alu_rst_n}, 32'd0);
        rst = 1'b0;
        #1;
        chk("alu_rst_n_high", {31'd0, alu_rst_n}, 32'd1);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("reset_bonus", {29'd0, alu_bonus}, 32'd0);
        chk_out("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ADD overflow, with latency check
        drive(1'b1, 4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("add_s1_ctrl", {28'd0, alu_ctrl}, 32'h2);
        chk("add_s1_src1", alu_src1, 32'h7FFF_FFFF);
        chk("add_latency_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk_out("add", 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // SUB 5-5 then AND back-to-back
        drive(1'b1, 4'd3, 32'd5, 32'd5);
        tick();
        chk("sub_ctrl", {28'd0, alu_ctrl}, 32'h6);
        drive(1'b1, 4'd0, 32'hF0F0_F0F0, 32'hFFFF_0000);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk_out("sub", 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("and", 1'b1, 32'hF0F0_0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Compare ops back-to-back, one result per cycle
        drive(1'b1, 4'd6, 32'hFFFF_FFFF, 32'd1);
        tick();
        drive(1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk_out("slt", 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sge_bonus", {29'd0, alu_bonus}, 32'h1);
        drive(1'b1, 4'd9, 32'd7, 32'd7);
        tick();
        chk_out("sge", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_bonus", {29'd0, alu_bonus}, 32'h6);
        drive(1'b1, 4'd8, 32'd9, 32'd3);
        tick();
        chk_out("seq", 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sle_bonus", {29'd0, alu_bonus}, 32'h2);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        chk_out("sle", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: three ADDs offered, two accepted while stalled
        out_ready = 1'b0;
        drive(1'b1, 4'd2, 32'd1, 32'd1);
        #1;
        chk("bp_ready0", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_ready1", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 4'd2, 32'd2, 32'd2);
        tick();
        drive(1'b1, 4'd2, 32'd3, 32'd3);
        chk("bp_ready2", {31'd0, in_ready}, 32'd0);
        chk("bp_res_a", out_result, 32'd2);
        tick();
        chk("bp_ready3", {31'd0, in_ready}, 32'd0);
        chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
        chk("bp_res_hold1", out_result, 32'd2);
        chk("bp_s1_hold", alu_src1, 32'd2);
        tick();
        chk("bp_res_hold2", out_result, 32'd2);
        chk("bp_ready4", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("bp_res_b_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_res_b", out_result, 32'd4);
        tick();
        chk("bp_res_c_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_res_c", out_result, 32'd6);
        tick();
        chk("bp_drain", {31'd0, out_valid}, 32'd0);

        // Illegal op followed by a legal OR
        drive(1'b1, 4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        chk("ill_src1_zero", alu_src1, 32'd0);
        chk("ill_src2_zero", alu_src2, 32'd0);
        chk("ill_ctrl", {28'd0, alu_ctrl}, 32'd0);
        drive(1'b1, 4'd1, 32'd1, 32'd2);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk_out("illegal", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("or", 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset with two commands in flight
        out_ready = 1'b0;
        drive(1'b1, 4'd2, 32'd10, 32'd20);
        tick();
        drive(1'b1, 4'd3, 32'd50, 32'd8);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_ctrl", {28'd0, alu_ctrl}, 32'h6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_out("post_rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("post_rst_src1", alu_src1, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale_result", {31'd0, out_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_issue_stage
`default_nettype wire
